sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, pattern width in bits.
REQ-002 SHALL provide parameter GAP_LEN, default 2, idle cycles between repetitions; 0 means back-to-back.
REQ-003 SHALL provide parameter DEFAULT_PATTERN, default 8'b10101010, pattern register value after reset.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request one transmission burst.
REQ-007 SHALL have port abort  input  1  terminate the current burst.
REQ-008 SHALL have port pattern_load  input  1  write pattern_in to the pattern register.
REQ-009 SHALL have port pattern_in  input  DATA_W  new pattern value.
REQ-010 SHALL have port repeat_cnt  input  4  burst sends repeat_cnt+1 patterns.
REQ-011 SHALL have port ser_out  output  1  serial bit, MSB first.
REQ-012 SHALL have port ser_valid  output  1  ser_out carries a pattern or parity bit.
REQ-013 SHALL have port busy  output  1  burst in progress (SHIFT, GAP or DONE).
REQ-014 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, GAP and DONE, all outputs registered.
REQ-016 In IDLE, pattern_load=1 SHALL update the pattern register on that edge; while busy, pattern_load SHALL be ignored.
REQ-017 In IDLE, start=1 SHALL latch the pattern (pattern_in if pattern_load is also 1) and repeat_cnt into a shift register and repetition counter, then enter SHIFT.
REQ-018 The first bit (MSB) SHALL appear on ser_out with ser_valid=1 in the cycle after start is sampled, giving a latency of 1.
REQ-019 SHIFT SHALL emit one bit per cycle, for DATA_W cycles per pattern, with no stalls.
REQ-020 After the last bit, if repetitions remain, the FSM SHALL enter GAP for GAP_LEN cycles with ser_out=0 and ser_valid=0, then reload the latched pattern and re-enter SHIFT.
REQ-021 If GAP_LEN=0, the next pattern's MSB SHALL follow the previous LSB in the very next cycle.
REQ-022 After the final pattern, the FSM SHALL enter DONE for one cycle with done=1, busy=1 and ser_valid=0, then return to IDLE.
REQ-023 start while busy SHALL be ignored; start sampled in the DONE cycle SHALL be ignored.
REQ-024 abort=1 in SHIFT, GAP or DONE SHALL force IDLE at the next edge, with ser_valid=0, busy=0 and no done pulse; abort has priority over all other transitions.
REQ-025 abort in IDLE SHALL have no effect; abort together with start in IDLE SHALL suppress the start.
REQ-026 repeat_cnt=15 SHALL send 16 patterns, and the repetition counter SHALL not wrap.
REQ-027 In IDLE, ser_out=0, ser_valid=0, busy=0 and done=0.

Reset
REQ-028 rst SHALL immediately force IDLE, ser_out=0, ser_valid=0, busy=0 and done=0, and pattern register=DEFAULT_PATTERN, including mid-burst.
REQ-029 The first start after rst deassertion SHALL be accepted on the first rising edge with rst low.

Configuration
REQ-030 Macro SEQ_GEN_PARITY_EN defined: after each pattern's LSB, one extra SHIFT cycle SHALL emit the even-parity bit (XOR of the pattern) with ser_valid=1, making each pattern DATA_W+1 cycles.
REQ-031 Macro SEQ_GEN_PARITY_EN undefined: no parity cycle SHALL be emitted, and the parity logic SHALL not exist.

Verification
REQ-032 After reset with default pattern, start=1 and repeat_cnt=0 -> ser_out 1,0,1,0,1,0,1,0 on cycles 1-8 with ser_valid=1; done=1 on cycle 9; busy=0 on cycle 10.
REQ-033 pattern_load=1, pattern_in=8'hC3, start=1 in the same cycle, repeat_cnt=1, GAP_LEN=2 -> 11000011, two cycles with ser_valid=0, 11000011, then done.
REQ-034 abort=1 on cycle 4 of a burst -> ser_valid=0 and busy=0 from cycle 5, no done pulse; a new start on cycle 6 begins cleanly with the MSB on cycle 7.
REQ-035 rst asserted during the GAP of a repeat_cnt=3 burst -> outputs 0 immediately; pattern register reads back 8'hAA via the next burst.
REQ-036 start pulsed during SHIFT and during DONE -> ignored, exactly repeat_cnt+1 patterns sent and one done pulse.
REQ-037 With SEQ_GEN_PARITY_EN defined, pattern 8'h07 -> 00000111 then parity bit 1, with ser_valid high for 9 cycles.

Source files
------------

// File: rtl/sequence_generator.sv
// sequence_generator
//   Serialises a DATA_W-bit pattern MSB first as a burst of repeat_cnt+1
//   copies. Copies are separated by GAP_LEN idle cycles. done pulses for one
//   cycle at the end of a complete burst. abort returns to IDLE with no done.
//   All outputs are registered.
//
// Optional feature (macro SEQ_GEN_PARITY_EN):
//   When defined, each copy is followed by one extra valid cycle that carries
//   the even-parity bit (XOR of the pattern).
//   When undefined, no parity logic is built.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active high
//   start        in   request one burst (sampled in IDLE only)
//   abort        in   terminate the current burst
//   pattern_load in   write pattern_in to the pattern register (IDLE only)
//   pattern_in   in   [DATA_W-1:0] new pattern value
//   repeat_cnt   in   [3:0] burst length minus one
//   ser_out      out  serial bit
//   ser_valid    out  ser_out carries a pattern or parity bit
//   busy         out  burst in progress (SHIFT, GAP or DONE)
//   done         out  one-cycle pulse on burst completion
module sequence_generator #(
  parameter int                DATA_W          = 8,
  parameter int                GAP_LEN         = 2,
  parameter logic [DATA_W-1:0] DEFAULT_PATTERN = DATA_W'(8'b10101010)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pattern_load,
  input  logic [DATA_W-1:0] pattern_in,
  input  logic [3:0]        repeat_cnt,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  localparam int BC_W  = $clog2(DATA_W + 2);
  localparam int GAP_W = (GAP_LEN < 1) ? 1 : $clog2(GAP_LEN + 1);
`ifdef SEQ_GEN_PARITY_EN
  localparam int LAST_BIT = DATA_W + 1;
`else
  localparam int LAST_BIT = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef SEQ_GEN_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] value);
    return ^value;
  endfunction
`endif

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   pattern_r, pattern_s;
  logic [DATA_W-1:0]   latched_r, latched_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic [DATA_W-1:0]   load_val_s;
  logic [BC_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [3:0]          rep_r, rep_s;
  logic [GAP_W-1:0]    gap_r, gap_s;
  logic                next_bit_s;
  logic                ser_out_s, ser_valid_s, busy_s, done_s;

  // Bit that follows the current one inside a copy: the parity bit once all
  // data bits are out, otherwise the head of the shift register.
  always_comb begin
`ifdef SEQ_GEN_PARITY_EN
    if (bit_cnt_r == BC_W'(DATA_W)) begin
      next_bit_s = even_parity(latched_r);
    end else begin
      next_bit_s = shift_r[DATA_W-1];
    end
`else
    next_bit_s = shift_r[DATA_W-1];
`endif
  end

  // Next-state and next-output logic. shift_r holds the bits not yet sent,
  // so the output register always shows the bit being emitted this cycle.
  always_comb begin
    state_s     = state_r;
    pattern_s   = pattern_r;
    latched_s   = latched_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    rep_s       = rep_r;
    gap_s       = gap_r;
    load_val_s  = pattern_r;
    ser_out_s   = 1'b0;
    ser_valid_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pattern_load) begin
          pattern_s  = pattern_in;
          load_val_s = pattern_in;
        end else begin
          pattern_s  = pattern_r;
          load_val_s = pattern_r;
        end
        // abort in the same cycle suppresses the start
        if (start && !abort) begin
          state_s     = S_SHIFT;
          latched_s   = load_val_s;
          shift_s     = {load_val_s[DATA_W-2:0], 1'b0};
          bit_cnt_s   = BC_W'(1);
          rep_s       = repeat_cnt;
          ser_out_s   = load_val_s[DATA_W-1];
          ser_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (bit_cnt_r != BC_W'(LAST_BIT)) begin
          state_s     = S_SHIFT;
          shift_s     = {shift_r[DATA_W-2:0], 1'b0};
          bit_cnt_s   = bit_cnt_r + BC_W'(1);
          ser_out_s   = next_bit_s;
          ser_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else if (rep_r != 4'd0) begin
          rep_s  = rep_r - 4'd1;
          busy_s = 1'b1;
          if (GAP_LEN == 0) begin
            // back-to-back: next MSB directly follows this LSB
            state_s     = S_SHIFT;
            shift_s     = {latched_r[DATA_W-2:0], 1'b0};
            bit_cnt_s   = BC_W'(1);
            ser_out_s   = latched_r[DATA_W-1];
            ser_valid_s = 1'b1;
          end else begin
            state_s = S_GAP;
            gap_s   = GAP_W'(1);
          end
        end else begin
          state_s = S_DONE;
          done_s  = 1'b1;
          busy_s  = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (gap_r == GAP_W'(GAP_LEN)) begin
          state_s     = S_SHIFT;
          shift_s     = {latched_r[DATA_W-2:0], 1'b0};
          bit_cnt_s   = BC_W'(1);
          ser_out_s   = latched_r[DATA_W-1];
          ser_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else begin
          state_s = S_GAP;
          gap_s   = gap_r + GAP_W'(1);
          busy_s  = 1'b1;
        end
      end
      S_DONE: begin
        // start here is ignored; abort leads to IDLE just the same
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      pattern_r <= DEFAULT_PATTERN;
      latched_r <= DEFAULT_PATTERN;
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
      rep_r     <= 4'd0;
      gap_r     <= {GAP_W{1'b0}};
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      pattern_r <= pattern_s;
      latched_r <= latched_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      rep_r     <= rep_s;
      gap_r     <= gap_s;
      ser_out   <= ser_out_s;
      ser_valid <= ser_valid_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator
//   Directed bench for sequence_generator (DATA_W=8, GAP_LEN=2).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_sequence_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       pattern_load;
  logic [7:0] pattern_in;
  logic [3:0] repeat_cnt;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  sequence_generator #(
    .DATA_W          (8),
    .GAP_LEN         (2),
    .DEFAULT_PATTERN (8'hAA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .repeat_cnt   (repeat_cnt),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drive a one-cycle start; returns at the falling edge of cycle 1.
  task automatic pulse_start(input logic [3:0] rep, input logic load, input logic [7:0] pat);
    start        = 1'b1;
    repeat_cnt   = rep;
    pattern_load = load;
    pattern_in   = pat;
    cyc();
    start        = 1'b0;
    pattern_load = 1'b0;
  endtask

  // Check one copy of pat bit by bit; at bit index poke, pulse start and a
  // pattern_load of 8'h55 (both must be ignored while busy).
  task automatic expect_bits(input string tag, input logic [7:0] pat, input int poke);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s bit%0d", tag, i), {31'd0, ser_out}, {31'd0, pat[7-i]});
      check($sformatf("%s valid%0d", tag, i), {31'd0, ser_valid}, 32'd1);
      check($sformatf("%s busy%0d", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s done%0d", tag, i), {31'd0, done}, 32'd0);
      if (i == poke) begin
        start        = 1'b1;
        pattern_load = 1'b1;
        pattern_in   = 8'h55;
      end else begin
        start        = 1'b0;
        pattern_load = 1'b0;
      end
      cyc();
    end
    start        = 1'b0;
    pattern_load = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    check($sformatf("%s parity", tag), {31'd0, ser_out}, {31'd0, ^pat});
    check($sformatf("%s parity_valid", tag), {31'd0, ser_valid}, 32'd1);
    cyc();
`endif
  endtask

  task automatic expect_gap(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s gap_valid%0d", tag, i), {31'd0, ser_valid}, 32'd0);
      check($sformatf("%s gap_out%0d", tag, i), {31'd0, ser_out}, 32'd0);
      check($sformatf("%s gap_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      cyc();
    end
  endtask

  // DONE cycle, then two idle cycles; start may be pulsed in the DONE cycle.
  task automatic expect_done(input string tag, input logic poke);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " done_busy"}, {31'd0, busy}, 32'd1);
    check({tag, " done_valid"}, {31'd0, ser_valid}, 32'd0);
    start = poke;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s idle_busy%0d", tag, i), {31'd0, busy}, 32'd0);
      check($sformatf("%s idle_done%0d", tag, i), {31'd0, done}, 32'd0);
      check($sformatf("%s idle_valid%0d", tag, i), {31'd0, ser_valid}, 32'd0);
      check($sformatf("%s idle_out%0d", tag, i), {31'd0, ser_out}, 32'd0);
      cyc();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    pattern_load = 1'b0;
    pattern_in   = 8'h00;
    repeat_cnt   = 4'd0;
    cyc();
    cyc();
    check("reset ser_out", {31'd0, ser_out}, 32'd0);
    check("reset ser_valid", {31'd0, ser_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    // Default pattern, start on the first edge after reset release.
    rst = 1'b0;
    pulse_start(4'd0, 1'b0, 8'h00);
    expect_bits("default", 8'hAA, -1);
    expect_done("default", 1'b0);

    // Load and start together, two copies separated by a 2-cycle gap.
    pulse_start(4'd1, 1'b1, 8'hC3);
    expect_bits("c3_a", 8'hC3, -1);
    expect_gap("c3");
    expect_bits("c3_b", 8'hC3, -1);
    expect_done("c3", 1'b0);

    // Abort on cycle 4, restart on cycle 6.
    pulse_start(4'd0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort bit%0d", i), {31'd0, ser_out}, {31'd0, 1'b1 & (i < 2)});
      check($sformatf("abort valid%0d", i), {31'd0, ser_valid}, 32'd1);
      if (i == 3) abort = 1'b1;
      cyc();
    end
    abort = 1'b0;
    check("abort c5 valid", {31'd0, ser_valid}, 32'd0);
    check("abort c5 busy", {31'd0, busy}, 32'd0);
    check("abort c5 done", {31'd0, done}, 32'd0);
    cyc();
    check("abort c6 busy", {31'd0, busy}, 32'd0);
    check("abort c6 done", {31'd0, done}, 32'd0);
    pulse_start(4'd0, 1'b0, 8'h00);
    expect_bits("restart", 8'hC3, -1);
    expect_done("restart", 1'b0);

    // start/pattern_load while busy and start in DONE are ignored.
    pulse_start(4'd1, 1'b0, 8'h00);
    expect_bits("ign_a", 8'hC3, 3);
    expect_gap("ign");
    expect_bits("ign_b", 8'hC3, -1);
    expect_done("ign", 1'b1);
    pulse_start(4'd0, 1'b0, 8'h00);
    expect_bits("noload", 8'hC3, -1);
    expect_done("noload", 1'b0);

    // abort with start in IDLE suppresses the start.
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start valid", {31'd0, ser_valid}, 32'd0);
    check("abort_start busy", {31'd0, busy}, 32'd0);

    // repeat_cnt=15 sends 16 copies.
    pulse_start(4'd15, 1'b0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      expect_bits($sformatf("r15_%0d", k), 8'hC3, -1);
      if (k < 15) expect_gap($sformatf("r15_%0d", k));
    end
    expect_done("r15", 1'b0);

    // Reset in the gap of a repeat_cnt=3 burst.
    pulse_start(4'd3, 1'b0, 8'h00);
    expect_bits("rstgap", 8'hC3, -1);
    #2;
    rst = 1'b1;
    #1;
    check("rstgap ser_out", {31'd0, ser_out}, 32'd0);
    check("rstgap ser_valid", {31'd0, ser_valid}, 32'd0);
    check("rstgap busy", {31'd0, busy}, 32'd0);
    check("rstgap done", {31'd0, done}, 32'd0);
    cyc();
    rst = 1'b0;
    pulse_start(4'd0, 1'b0, 8'h00);
    expect_bits("after_rst", 8'hAA, -1);
    expect_done("after_rst", 1'b0);

`ifdef SEQ_GEN_PARITY_EN
    // 8'h07 carries odd weight, so its parity bit is 1.
    pulse_start(4'd0, 1'b1, 8'h07);
    expect_bits("par07", 8'h07, -1);
    expect_done("par07", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
